// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: MAR/MDR holder and memory/I-O transaction responder for the LC-3 datapath.
// RAM accesses take WAIT_STATES+1 ACCESS cycles; device registers complete in a single cycle.
module lc3_mem_ctrl #(
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [15:0] KBSR_ADDR   = 16'hFE00,
   parameter logic [15:0] DSR_ADDR    = 16'hFE04,
   parameter logic [15:0] MCR_ADDR    = 16'hFFFE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] i_bus,
   input  logic        i_ld_mar,
   input  logic        i_ld_mdr,
   input  logic        i_mio_en,
   input  logic        i_r_w,
   output logic [15:0] o_mar_out,
   output logic [15:0] o_mdr_out,
   output logic        o_mem_ready,
   output logic [15:0] o_ram_addr,
   output logic [15:0] o_ram_wdata,
   output logic        o_ram_en,
   output logic        o_ram_we,
   input  logic [15:0] i_ram_rdata,
   input  logic        i_kb_valid,
   input  logic [7:0]  i_kb_data,
   output logic        o_kb_ready,
   output logic        o_disp_valid,
   output logic [7:0]  o_disp_data,
   input  logic        i_disp_ready,
   output logic        o_run
);

   localparam logic [15:0] KBDR_ADDR = KBSR_ADDR + 16'd2;
   localparam logic [15:0] DDR_ADDR  = DSR_ADDR + 16'd2;
   localparam logic [3:0]  RAM_CNT   = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
   state_t r_state, w_state_next;

   logic [15:0] r_mar, r_mdr, r_ddr, r_mcr;
   logic [7:0]  r_kbdr;
   logic        r_kbsr_full, r_disp_valid, r_rw, r_io;
   logic [3:0]  r_cnt;
   logic [15:0] w_mar_next, w_io_rdata;
   logic        w_mar_io, w_last, w_complete, w_mem_ready, w_ram_en, w_ram_we;
   logic        w_kbdr_rd, w_ddr_wr, w_mcr_wr;

   // Device select is decided from the address MAR will hold after this edge.
   assign w_mar_next = i_ld_mar ? i_bus : r_mar;
   assign w_mar_io   = (w_mar_next[15:8] == KBSR_ADDR[15:8]) ||
                       (w_mar_next[15:8] == DSR_ADDR[15:8])  ||
                       (w_mar_next[15:8] == MCR_ADDR[15:8]);
   assign w_last     = (r_cnt == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_ram_en     = 1'b0;
      w_ram_we     = 1'b0;
      w_mem_ready  = 1'b0;
      w_complete   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_mio_en) w_state_next = S_ACCESS;
         end
         S_ACCESS: begin
            w_ram_en = ~r_io;
            // A write strobe in the final cycle is not retracted by a late abort.
            w_ram_we = ~r_io & r_rw & w_last;
            if (!i_mio_en) begin
               w_state_next = S_IDLE;
            end else if (w_last) begin
               w_state_next = S_DONE;
               w_complete   = 1'b1;
            end
         end
         S_DONE: begin
            w_mem_ready  = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 4'd0;
         r_rw  <= 1'b0;
         r_io  <= 1'b0;
      end else if (r_state == S_IDLE && i_mio_en) begin
         r_cnt <= w_mar_io ? 4'd0 : RAM_CNT;
         r_rw  <= i_r_w;
         r_io  <= w_mar_io;
      end else if (r_state == S_ACCESS && !w_last) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   always_comb begin
      w_io_rdata = 16'h0000;
      if (r_mar == KBSR_ADDR)      w_io_rdata = {r_kbsr_full, 15'b0};
      else if (r_mar == KBDR_ADDR) w_io_rdata = {8'b0, r_kbdr};
      else if (r_mar == DSR_ADDR)  w_io_rdata = {~r_disp_valid, 15'b0};
      else if (r_mar == DDR_ADDR)  w_io_rdata = r_ddr;
      else if (r_mar == MCR_ADDR)  w_io_rdata = r_mcr;
   end

   assign w_kbdr_rd = w_complete & ~r_rw & r_io & (r_mar == KBDR_ADDR);
   assign w_ddr_wr  = w_complete &  r_rw & r_io & (r_mar == DDR_ADDR);
   assign w_mcr_wr  = w_complete &  r_rw & r_io & (r_mar == MCR_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mar <= 16'h0000;
         r_mdr <= 16'h0000;
      end else if (r_state == S_IDLE) begin
         if (i_ld_mar) r_mar <= i_bus;
         if (i_ld_mdr && !i_mio_en) r_mdr <= i_bus;
      end else if (w_complete && !r_rw) begin
         r_mdr <= r_io ? w_io_rdata : i_ram_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_kbsr_full  <= 1'b0;
         r_kbdr       <= 8'h00;
         r_disp_valid <= 1'b0;
         r_ddr        <= 16'h0000;
         r_mcr        <= 16'h8000;
      end else begin
         // Reading KBDR frees the slot; capture waits one cycle for the held source.
         if (w_kbdr_rd) begin
            r_kbsr_full <= 1'b0;
         end else if (i_kb_valid && !r_kbsr_full) begin
            r_kbsr_full <= 1'b1;
            r_kbdr      <= i_kb_data;
         end
         if (w_ddr_wr) begin
            r_ddr        <= r_mdr;
            r_disp_valid <= 1'b1;
         end else if (r_disp_valid && i_disp_ready) begin
            r_disp_valid <= 1'b0;
         end
         if (w_mcr_wr) r_mcr <= r_mdr;
      end
   end

   assign o_mar_out    = r_mar;
   assign o_mdr_out    = r_mdr;
   assign o_mem_ready  = w_mem_ready;
   assign o_ram_addr   = r_mar;
   assign o_ram_wdata  = r_mdr;
   assign o_ram_en     = w_ram_en;
   assign o_ram_we     = w_ram_we;
   assign o_kb_ready   = ~r_kbsr_full;
   assign o_disp_valid = r_disp_valid;
   assign o_disp_data  = r_ddr[7:0];
   assign o_run        = r_mcr[15];

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Testbench for lc3_mem_ctrl: table-driven RAM/I-O transactions checked through a
// scoreboard queue, plus hand-written keyboard, display, abort and reset sequences.
module tb_lc3_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] bus;
   logic        ld_mar, ld_mdr, mio_en, r_w;
   logic [15:0] mar_out, mdr_out, ram_addr, ram_wdata, ram_rdata;
   logic        mem_ready, ram_en, ram_we;
   logic        kb_valid, kb_ready, disp_valid, disp_ready, run;
   logic [7:0]  kb_data, disp_data;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       nm;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        rw;
      logic [15:0] exp_mdr;
      int          exp_lat;
      int          exp_ram;
   } vec_t;

   typedef struct {
      string       nm;
      logic [15:0] mdr;
   } sb_t;

   vec_t vecs [0:10];
   sb_t  sb_q [$];
   logic [15:0] tb_ram [0:65535];

   always #5 clk = ~clk;

   lc3_mem_ctrl #(.WAIT_STATES(2)) dut (
      .clk(clk), .rst_n(rst_n), .i_bus(bus), .i_ld_mar(ld_mar), .i_ld_mdr(ld_mdr),
      .i_mio_en(mio_en), .i_r_w(r_w), .o_mar_out(mar_out), .o_mdr_out(mdr_out),
      .o_mem_ready(mem_ready), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
      .o_ram_en(ram_en), .o_ram_we(ram_we), .i_ram_rdata(ram_rdata),
      .i_kb_valid(kb_valid), .i_kb_data(kb_data), .o_kb_ready(kb_ready),
      .o_disp_valid(disp_valid), .o_disp_data(disp_data), .i_disp_ready(disp_ready),
      .o_run(run)
   );

   // Synchronous RAM with registered read.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) tb_ram[ram_addr] <= ram_wdata;
         ram_rdata <= tb_ram[ram_addr];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s actual=%h required=%h", nm, act, exp);
      end else begin
         $display("[TB] ok   %s = %h", nm, act);
      end
   endtask

   task automatic run_txn(input string nm, input logic [15:0] addr, input logic [15:0] data,
                          input logic rw, input logic [15:0] exp_mdr, input int exp_lat,
                          input int exp_ram);
      int  lat, we_cnt, we_at, en_cnt;
      sb_t e;
      lat = 0; we_cnt = 0; we_at = 0; en_cnt = 0;
      @(negedge clk); bus = addr; ld_mar = 1'b1;
      @(negedge clk); ld_mar = 1'b0; bus = data; ld_mdr = rw;
      @(negedge clk); ld_mdr = 1'b0; r_w = rw; mio_en = 1'b1;
      sb_q.push_back('{nm, exp_mdr});
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (ram_en) en_cnt++;
         if (ram_we) begin we_cnt++; we_at = k; end
         if (mem_ready) begin lat = k; break; end
      end
      mio_en = 1'b0;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (lat != 0) chk({e.nm, "_mdr"}, {16'h0, mdr_out}, {16'h0, e.mdr});
      end
      chk({nm, "_lat"}, lat, exp_lat);
      chk({nm, "_ram_en_cyc"}, en_cnt, exp_ram);
      chk({nm, "_we_at"}, we_at, (rw && exp_ram != 0) ? exp_lat - 1 : 0);
      @(negedge clk);
      chk({nm, "_ready_pulse"}, {31'h0, mem_ready}, 32'h0);
   endtask

   initial begin
      vecs[0]  = '{"w3000", 16'h3000, 16'hABCD, 1'b1, 16'hABCD, 4, 3};
      vecs[1]  = '{"w3001", 16'h3001, 16'h1234, 1'b1, 16'h1234, 4, 3};
      vecs[2]  = '{"w0000", 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 4, 3};
      vecs[3]  = '{"wFDFF", 16'hFDFF, 16'h5A5A, 1'b1, 16'h5A5A, 4, 3};
      vecs[4]  = '{"r3000", 16'h3000, 16'h0000, 1'b0, 16'hABCD, 4, 3};
      vecs[5]  = '{"r0000", 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 4, 3};
      vecs[6]  = '{"r3001", 16'h3001, 16'h0000, 1'b0, 16'h1234, 4, 3};
      vecs[7]  = '{"rFDFF", 16'hFDFF, 16'h0000, 1'b0, 16'h5A5A, 4, 3};
      vecs[8]  = '{"rFE10", 16'hFE10, 16'h0000, 1'b0, 16'h0000, 2, 0};
      vecs[9]  = '{"rMCR",  16'hFFFE, 16'h0000, 1'b0, 16'h8000, 2, 0};
      vecs[10] = '{"rDSR",  16'hFE04, 16'h0000, 1'b0, 16'h8000, 2, 0};

      rst_n = 1'b0; bus = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0;
      kb_valid = 0; kb_data = '0; disp_ready = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mar", {16'h0, mar_out}, 32'h0);
      chk("rst_mdr", {16'h0, mdr_out}, 32'h0);
      chk("rst_ctl", {28'h0, mem_ready, ram_en, ram_we, disp_valid}, 32'h0);
      chk("rst_kb_run", {30'h0, kb_ready, run}, 32'h3);
      chk("rst_disp_data", {24'h0, disp_data}, 32'h0);

      for (int i = 0; i <= 10; i++)
         run_txn(vecs[i].nm, vecs[i].addr, vecs[i].wdata, vecs[i].rw,
                 vecs[i].exp_mdr, vecs[i].exp_lat, vecs[i].exp_ram);

      // Keyboard capture and KBDR-read clear.
      @(negedge clk); kb_valid = 1'b1; kb_data = 8'h41;
      @(negedge clk); kb_valid = 1'b0;
      chk("kb_ready_full", {31'h0, kb_ready}, 32'h0);
      run_txn("rKBSR1", 16'hFE00, 16'h0, 1'b0, 16'h8000, 2, 0);
      run_txn("rKBDR",  16'hFE02, 16'h0, 1'b0, 16'h0041, 2, 0);
      run_txn("rKBSR2", 16'hFE00, 16'h0, 1'b0, 16'h0000, 2, 0);
      chk("kb_ready_empty", {31'h0, kb_ready}, 32'h1);

      // Display write, status, consume, overwrite.
      run_txn("wDDR42", 16'hFE06, 16'h0042, 1'b1, 16'h0042, 2, 0);
      chk("disp_42", {23'h0, disp_valid, disp_data}, {23'h0, 1'b1, 8'h42});
      run_txn("rDSRbusy", 16'hFE04, 16'h0, 1'b0, 16'h0000, 2, 0);
      @(negedge clk); disp_ready = 1'b1;
      @(negedge clk); disp_ready = 1'b0;
      chk("disp_consumed", {31'h0, disp_valid}, 32'h0);
      run_txn("rDSRfree", 16'hFE04, 16'h0, 1'b0, 16'h8000, 2, 0);
      run_txn("wDDR43", 16'hFE06, 16'h0043, 1'b1, 16'h0043, 2, 0);
      run_txn("wDDR44", 16'hFE06, 16'h0044, 1'b1, 16'h0044, 2, 0);
      chk("disp_overwrite", {23'h0, disp_valid, disp_data}, {23'h0, 1'b1, 8'h44});
      @(negedge clk); disp_ready = 1'b1;
      @(negedge clk); disp_ready = 1'b0;

      // RAM write aborted after one ACCESS cycle leaves RAM untouched.
      begin
         int bad;
         bad = 0;
         run_txn("w3100", 16'h3100, 16'h1111, 1'b1, 16'h1111, 4, 3);
         @(negedge clk); bus = 16'h3100; ld_mar = 1'b1;
         @(negedge clk); ld_mar = 1'b0; bus = 16'h2222; ld_mdr = 1'b1;
         @(negedge clk); ld_mdr = 1'b0; r_w = 1'b1; mio_en = 1'b1;
         @(negedge clk); mio_en = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (ram_we || mem_ready) bad++;
            @(negedge clk);
         end
         chk("abort_no_we_ready", bad, 0);
         chk("abort_mdr", {16'h0, mdr_out}, 32'h2222);
         run_txn("r3100", 16'h3100, 16'h0, 1'b0, 16'h1111, 4, 3);
      end

      // MCR halt, then reset mid-read.
      run_txn("wMCR0", 16'hFFFE, 16'h0000, 1'b1, 16'h0000, 2, 0);
      chk("run_halted", {31'h0, run}, 32'h0);
      begin
         int rdy;
         rdy = 0;
         @(negedge clk); bus = 16'h3000; ld_mar = 1'b1;
         @(negedge clk); ld_mar = 1'b0; r_w = 1'b0; mio_en = 1'b1;
         @(negedge clk);
         @(negedge clk);
         rst_n = 1'b0; mio_en = 1'b0;
         #1;
         chk("rstmid_mar_mdr", {mar_out, mdr_out}, 32'h0);
         chk("rstmid_ctl", {29'h0, mem_ready, ram_en, ram_we}, 32'h0);
         chk("rstmid_run", {31'h0, run}, 32'h1);
         @(negedge clk); rst_n = 1'b1;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_ready) rdy++;
         end
         chk("rstmid_no_ready", rdy, 0);
         chk("rstmid_dev", {30'h0, kb_ready, disp_valid}, 32'h2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
